// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between a CPU core (initiator) and the data-memory
// responder. The initiator holds req and every request field steady until it
// sees the one-cycle ready pulse.
//   req           initiator -> responder  transaction request
//   n_rw          initiator -> responder  0 = read, 1 = write
//   address_bus   initiator -> responder  byte address
//   data_in_bus   initiator -> responder  write data
//   be            initiator -> responder  byte enables (writes only)
//   data_out_bus  responder -> initiator  registered read data
//   ready         responder -> initiator  one-cycle completion pulse
//   err           responder -> initiator  error flag, meaningful only with ready
// ---------------------------------------------------------------------------
interface mem_responder_if;
  logic        req;
  logic        n_rw;
  logic [31:0] address_bus;
  logic [31:0] data_in_bus;
  logic [3:0]  be;
  logic [31:0] data_out_bus;
  logic        ready;
  logic        err;

  modport master (
    output req, n_rw, address_bus, data_in_bus, be,
    input  data_out_bus, ready, err
  );

  modport slave (
    input  req, n_rw, address_bus, data_in_bus, be,
    output data_out_bus, ready, err
  );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Word-addressed memory target for the CPU's n_rw bus. A request is captured
// in IDLE, held for WAIT_STATES extra cycles, then the read or byte-enabled
// write is performed on the internal array and answered with a one-cycle
// ready pulse. Misaligned or out-of-range addresses answer with err=1, read
// data 0 and no array write.
//   clk      rising-edge clock
//   n_reset  asynchronous, active-low reset
//   bus      mem_responder_if slave modport (request in, response out)
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   BASE_ADDR    byte address of word 0, aligned to 4*DEPTH_WORDS
//   WAIT_STATES  extra cycles between capture and access (0..15)
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input logic           clk,
  input logic           n_reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // One past the last valid byte, kept in 33 bits so a region ending at the
  // top of the 4 GB space does not wrap to zero.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               w_capture;
  logic               w_access;
  logic [3:0]         r_waitCount;
  logic               r_nRw;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [31:0]        r_dataOut;
  logic               r_ready;
  logic               r_err;
  logic [32:0]        w_diff;
  logic               w_error;
  logic [IDX_W-1:0]   w_index;
  logic [31:0]        r_mem [DEPTH_WORDS];

  // State register. Reset drops straight to IDLE, which also cancels any
  // pending access because the access strobe is only raised from WAIT.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state logic plus the two strobes that drive the datapath: capture
  // of the request in IDLE and the actual memory access at the end of WAIT.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_capture   = 1'b1;
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (r_waitCount == 4'd0) begin
          w_access    = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Address decode on the captured address. The 33-bit subtraction gives the
  // below-base check through its borrow bit and the word offset in one step.
  always_comb begin
    w_diff  = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    w_error = (r_addr[1:0] != 2'b00) || w_diff[32] || ({1'b0, r_addr} >= END_ADDR);
    w_index = IDX_W'(w_diff >> 2);
  end

  // Request capture, wait-state countdown and registered response. ready and
  // err follow the access strobe, so they rise at the access edge and fall at
  // the next one, and err can never be high without ready.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_waitCount <= 4'd0;
      r_nRw       <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_dataOut   <= 32'd0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_nRw       <= bus.n_rw;
        r_addr      <= bus.address_bus;
        r_wdata     <= bus.data_in_bus;
        r_be        <= bus.be;
        r_waitCount <= 4'(WAIT_STATES);
      end else if (r_state == WAIT && r_waitCount != 4'd0) begin
        r_waitCount <= r_waitCount - 4'd1;
      end
      r_ready <= w_access;
      r_err   <= w_access & w_error;
      if (w_access) begin
        if (w_error)     r_dataOut <= 32'd0;
        else if (!r_nRw) r_dataOut <= r_mem[w_index];
      end
    end
  end

  // Storage array, deliberately without reset so it maps onto plain RAM.
  // Only enabled bytes of a legal write are updated; be=0 is a silent no-op.
  always_ff @(posedge clk) begin
    if (w_access && r_nRw && !w_error) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign bus.data_out_bus = r_dataOut;
  assign bus.ready        = r_ready;
  assign bus.err          = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Three instances share one clock:
//   dutA  WAIT_STATES=1  reset release, write/read, byte enables, errors
//   dutB  WAIT_STATES=0  back-to-back reads with req held high
//   dutC  WAIT_STATES=3  reset pulled mid-WAIT aborts a write
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB, rstC;

  mem_responder_if busA();
  mem_responder_if busB();
  mem_responder_if busC();

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1))
    dutA (.clk(clk), .n_reset(rstA), .bus(busA.slave));
  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0))
    dutB (.clk(clk), .n_reset(rstB), .bus(busB.slave));
  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3))
    dutC (.clk(clk), .n_reset(rstC), .bus(busC.slave));

  // Per-instance drive and observe arrays, indexed 0=A, 1=B, 2=C.
  logic        drvReq  [3];
  logic        drvRw   [3];
  logic [31:0] drvAddr [3];
  logic [31:0] drvData [3];
  logic [3:0]  drvBe   [3];
  logic        obsReady[3];
  logic        obsErr  [3];
  logic [31:0] obsData [3];

  assign busA.req = drvReq[0];  assign busA.n_rw = drvRw[0];
  assign busA.address_bus = drvAddr[0];  assign busA.data_in_bus = drvData[0];
  assign busA.be = drvBe[0];
  assign busB.req = drvReq[1];  assign busB.n_rw = drvRw[1];
  assign busB.address_bus = drvAddr[1];  assign busB.data_in_bus = drvData[1];
  assign busB.be = drvBe[1];
  assign busC.req = drvReq[2];  assign busC.n_rw = drvRw[2];
  assign busC.address_bus = drvAddr[2];  assign busC.data_in_bus = drvData[2];
  assign busC.be = drvBe[2];

  assign obsReady[0] = busA.ready;  assign obsErr[0] = busA.err;  assign obsData[0] = busA.data_out_bus;
  assign obsReady[1] = busB.ready;  assign obsErr[1] = busB.err;  assign obsData[1] = busB.data_out_bus;
  assign obsReady[2] = busC.ready;  assign obsErr[2] = busC.err;  assign obsData[2] = busC.data_out_bus;

  int checkCount = 0;
  int errorCount = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Put a request on the selected bus (fields and req together).
  task automatic driveReq(input int sel, input logic rw, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
    drvReq[sel]  = 1'b1;
    drvRw[sel]   = rw;
    drvAddr[sel] = addr;
    drvData[sel] = data;
    drvBe[sel]   = be;
  endtask

  // Wait for ready after a request has been placed before a rising edge.
  // Edge 1 is the capture edge, so ready is expected at edge 2+ws. Also
  // checks that ready/err are back low one edge later.
  task automatic waitResponse(input int sel, input int ws, input string tag,
                              output logic [31:0] rdata, output logic rerr);
    int  cnt  = 0;
    bit  seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (obsReady[sel]) seen = 1'b1;
    end
    drvReq[sel] = 1'b0;
    checkOutput({tag, " ready seen"}, 32'(seen), 32'd1);
    checkOutput({tag, " latency"}, 32'(cnt - 1), 32'(1 + ws));
    rdata = obsData[sel];
    rerr  = obsErr[sel];
    @(posedge clk); #1;
    checkOutput({tag, " pulse end"}, {30'd0, obsReady[sel], obsErr[sel]}, 32'd0);
  endtask

  // Full transaction: drive at the falling edge, then collect the response.
  task automatic applyStimulus(input int sel, input int ws, input string tag,
                               input logic rw, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be,
                               output logic [31:0] rdata, output logic rerr);
    @(negedge clk);
    driveReq(sel, rw, addr, data, be);
    waitResponse(sel, ws, tag, rdata, rerr);
  endtask

  logic [31:0] rdata;
  logic        rerr;

  // Directed test sequence.
  initial begin
    int pulses, firstAt, secondAt;
    logic [31:0] d1, d2;

    for (int i = 0; i < 3; i++) begin
      drvReq[i] = 1'b0; drvRw[i] = 1'b0; drvAddr[i] = 32'd0;
      drvData[i] = 32'd0; drvBe[i] = 4'd0;
    end
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;

    // Reset held with a write request pending on A: outputs stay at zero.
    driveReq(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ready", 32'(obsReady[0]), 32'd0);
    checkOutput("reset err",   32'(obsErr[0]),   32'd0);
    checkOutput("reset data",  obsData[0],       32'd0);

    // Release: the pending write is captured at the first edge after.
    @(negedge clk);
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    waitResponse(0, 1, "wr 0x10", rdata, rerr);
    checkOutput("wr 0x10 err", 32'(rerr), 32'd0);

    applyStimulus(0, 1, "rd 0x10", 1'b0, 32'h10, 32'h0, 4'h0, rdata, rerr);
    checkOutput("rd 0x10 err", 32'(rerr), 32'd0);
    checkOutput("rd 0x10 data", rdata, 32'hDEAD_BEEF);

    // Byte enables 0101 merge bytes 0 and 2 into the stored word.
    applyStimulus(0, 1, "wr 0x20 full", 1'b1, 32'h20, 32'h1122_3344, 4'hF, rdata, rerr);
    applyStimulus(0, 1, "wr 0x20 be5", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rdata, rerr);
    checkOutput("wr be5 data holds", rdata, 32'hDEAD_BEEF);
    applyStimulus(0, 1, "rd 0x20", 1'b0, 32'h20, 32'h0, 4'h0, rdata, rerr);
    checkOutput("rd 0x20 data", rdata, 32'h11BB_33DD);

    // be=0 write completes normally and changes nothing.
    applyStimulus(0, 1, "wr 0x20 be0", 1'b1, 32'h20, 32'h0, 4'b0000, rdata, rerr);
    checkOutput("wr be0 err", 32'(rerr), 32'd0);
    checkOutput("wr be0 data holds", rdata, 32'h11BB_33DD);
    applyStimulus(0, 1, "rd 0x20 again", 1'b0, 32'h20, 32'h0, 4'h0, rdata, rerr);
    checkOutput("rd 0x20 again data", rdata, 32'h11BB_33DD);

    // Last valid word of the array.
    applyStimulus(0, 1, "wr 0xFFC", 1'b1, 32'hFFC, 32'hCAFE_0001, 4'hF, rdata, rerr);
    checkOutput("wr 0xFFC err", 32'(rerr), 32'd0);
    applyStimulus(0, 1, "rd 0xFFC", 1'b0, 32'hFFC, 32'h0, 4'h0, rdata, rerr);
    checkOutput("rd 0xFFC data", rdata, 32'hCAFE_0001);

    // Misaligned read: err with data forced to zero.
    applyStimulus(0, 1, "rd 0x13", 1'b0, 32'h13, 32'h0, 4'h0, rdata, rerr);
    checkOutput("rd 0x13 err", 32'(rerr), 32'd1);
    checkOutput("rd 0x13 data", rdata, 32'd0);

    // Out-of-range write aliases onto word 0 if truncated; word 0 must survive.
    applyStimulus(0, 1, "wr 0x0", 1'b1, 32'h0, 32'h600D_D00D, 4'hF, rdata, rerr);
    applyStimulus(0, 1, "wr 0x1000", 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, rdata, rerr);
    checkOutput("wr 0x1000 err", 32'(rerr), 32'd1);
    applyStimulus(0, 1, "wr 0x22", 1'b1, 32'h22, 32'hFFFF_FFFF, 4'hF, rdata, rerr);
    checkOutput("wr 0x22 err", 32'(rerr), 32'd1);
    applyStimulus(0, 1, "rd 0x0", 1'b0, 32'h0, 32'h0, 4'h0, rdata, rerr);
    checkOutput("rd 0x0 err", 32'(rerr), 32'd0);
    checkOutput("rd 0x0 data", rdata, 32'h600D_D00D);

    // Back-to-back on B (no wait states): req held, address switched after
    // the first ready. Captures at edges 1 and 4, ready at 2 and 5.
    applyStimulus(1, 0, "B wr 0x10", 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, rdata, rerr);
    applyStimulus(1, 0, "B wr 0x14", 1'b1, 32'h14, 32'h1234_5678, 4'hF, rdata, rerr);
    @(negedge clk);
    driveReq(1, 1'b0, 32'h10, 32'h0, 4'h0);
    pulses = 0; firstAt = 0; secondAt = 0; d1 = 32'd0; d2 = 32'd0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (obsReady[1]) begin
        pulses++;
        if (pulses == 1) begin
          firstAt = c; d1 = obsData[1]; drvAddr[1] = 32'h14;
        end else begin
          secondAt = c; d2 = obsData[1]; drvReq[1] = 1'b0;
        end
      end
    end
    drvReq[1] = 1'b0;
    checkOutput("B pulse count", 32'(pulses), 32'd2);
    checkOutput("B first ready edge", 32'(firstAt), 32'd2);
    checkOutput("B ready spacing", 32'(secondAt - firstAt), 32'd3);
    checkOutput("B first data", d1, 32'h0BAD_F00D);
    checkOutput("B second data", d2, 32'h1234_5678);

    // Reset on C one cycle after capture of a write: no ready, no write.
    applyStimulus(2, 3, "C wr 0x40", 1'b1, 32'h40, 32'h5555_AAAA, 4'hF, rdata, rerr);
    @(negedge clk);
    driveReq(2, 1'b1, 32'h40, 32'hFFFF_0000, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstC = 1'b0;
    drvReq[2] = 1'b0;
    #1;
    checkOutput("C async reset ready", 32'(obsReady[2]), 32'd0);
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (obsReady[2]) pulses++;
    end
    @(negedge clk);
    rstC = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (obsReady[2]) pulses++;
    end
    checkOutput("C aborted pulses", 32'(pulses), 32'd0);
    applyStimulus(2, 3, "C rd 0x40", 1'b0, 32'h40, 32'h0, 4'h0, rdata, rerr);
    checkOutput("C rd 0x40 err", 32'(rerr), 32'd0);
    checkOutput("C rd 0x40 data", rdata, 32'h5555_AAAA);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory target that answers the CPU's bus transactions: the responder end of the core's `n_rw` read/write bus. It accepts a single request, inserts a configurable number of wait states, then performs the read or byte-enabled write on an internal RAM array. It returns the result with a one-cycle `ready` pulse and flags misaligned or out-of-range accesses. It sits between the CPU core and on-chip data memory.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `4*DEPTH_WORDS`.
- `WAIT_STATES`, 1: extra cycles between request capture and access; 0–15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `req`  in  1  initiator requests a transaction; held with all request fields until `ready`.
- `n_rw`  in  1  LOW = read, HIGH = write.
- `address_bus`  in  32  byte address.
- `data_in_bus`  in  32  write data.
- `be`  in  4  byte enables for writes; `be[i]` gates bits `[8i+7:8i]`.
- `data_out_bus`  out  32  read data, registered.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  error qualifier, valid only while `ready`=1.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: if `req`=1 at a rising edge, capture `n_rw`, address, write data and `be`. Load the wait counter with `WAIT_STATES` and go to WAIT. If `req`=0, stay in IDLE.
- WAIT: if counter ≠ 0, decrement it. If counter = 0, perform the access at this edge, register the response, set `ready`=1 and go to RESP.
- RESP: clear `ready` and `err`, then go to IDLE. `req` is not sampled in RESP.
- Error condition (evaluated on captured address):
  - `addr[1:0]` ≠ 0, or
  - `addr` < `BASE_ADDR`, or
  - `addr` ≥ `BASE_ADDR + 4*DEPTH_WORDS`.
- On error: no array write, `data_out_bus` ← 0, `err`=1 with `ready`.
- Word index = `(addr - BASE_ADDR) >> 2`, truncated to `log2(DEPTH_WORDS)` bits.
- Read: `data_out_bus` ← full word; `be` is ignored.
- Write: only bytes with `be[i]`=1 are updated. `be`=4'b0000 is a legal no-op write and still completes with `ready`. `data_out_bus` holds its previous value.
- The array is not cleared by reset. Its contents after power-up are undefined; the bench must write before reading.

## Timing
- Reset values: `data_out_bus`=0, `ready`=0, `err`=0, state IDLE, wait counter 0.
- Latency: a request captured at edge k completes at edge k+1+`WAIT_STATES`. `ready` is high only between that edge and the next one.
- Throughput: at most one transaction per `WAIT_STATES`+3 cycles. This includes the mandatory RESP cycle and the IDLE sampling cycle.
- Back-to-back: if `req` is still 1 in the IDLE cycle after RESP, it is taken as a new request.
- Request fields may change after `ready`. Changes between capture and `ready` are ignored, because the captured copy is used.
- Write-then-read to the same word: the read returns the new data, since the write completes before the next capture.
- Reset asserted mid-transaction, before the access edge: the transaction is aborted and no array write occurs. Outputs go to their reset values immediately (asynchronous).
- `err` is never 1 while `ready`=0.

## Test plan
- Reset: hold `n_reset`=0 with `req`=1 → `ready`=0, `err`=0, `data_out_bus`=0. Release; the first request is captured at the first edge after release.
- Write then read, `WAIT_STATES`=1: write 32'hDEAD_BEEF to addr 0x10 with `be`=4'hF, then read 0x10 → `ready` two edges after each capture, `err`=0, `data_out_bus`=32'hDEAD_BEEF.
- Byte enables: word 0x20 holds 32'h1122_3344; write 32'hAABB_CCDD with `be`=4'b0101, then read → 32'h11BB_33DD.
- Errors:
  - read addr 0x13 → `ready`=1, `err`=1, `data_out_bus`=0.
  - write addr `BASE_ADDR+4*DEPTH_WORDS` → `err`=1 and the array is unchanged.
- Back-to-back with `WAIT_STATES`=0: hold `req`=1 for two reads → captures are 3 cycles apart and exactly one `ready` pulse per transaction.
- Reset mid-WAIT (`WAIT_STATES`=3): start a write to 0x40, pull `n_reset` low one cycle after capture → `ready` never pulses and a later read of 0x40 returns the old value.
